data_cache: RTL and testbench

Direct-mapped, word-addressed data cache between the core's load/store path and a fixed-latency backing data memory. It returns one word per request with a completion flag `over`. On a miss it fills the requested block and prefetches the next sequential block. Writes are write-through.

---
 rtl/data_cache_pkg.sv | 31 +++
 rtl/data_mem.sv | 38 +++
 rtl/data_cache.sv | 186 ++++++++++++++++++
 tb/tb_data_cache.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared defaults, FSM state encoding and address-field width helpers for the data cache.
package data_cache_pkg;

  localparam int unsigned DEF_WORD_SIZE    = 32;
  localparam int unsigned DEF_BLOCK_WORDS  = 4;
  localparam int unsigned DEF_BLOCK_SIZE   = DEF_WORD_SIZE * DEF_BLOCK_WORDS;
  localparam int unsigned DEF_LINES        = 16;
  localparam int unsigned DEF_MEM_WORDS    = 1024;
  localparam int unsigned DEF_MISS_LATENCY = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_WRITE,
    S_DONE
  } cache_state_t;

  // Bits needed to index n entries (at least one bit).
  function automatic int unsigned field_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tag bits left after removing offset and index from the used address bits.
  function automatic int unsigned tag_w(input int unsigned mem_words,
                                        input int unsigned block_words,
                                        input int unsigned lines);
    return field_w(mem_words) - field_w(block_words) - field_w(lines);
  endfunction

endpackage

// File: rtl/data_mem.sv
// Backing data memory: synchronous word write, combinational read of the addressed block and the next one.
module data_mem
  import data_cache_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = DEF_WORD_SIZE,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int unsigned MEM_WORDS   = DEF_MEM_WORDS
) (
  input  logic                               clk,
  input  logic [field_w(MEM_WORDS)-1:0]      addr,
  input  logic                               read,
  input  logic                               write,
  input  logic [WORD_SIZE-1:0]               wdata,
  output logic [WORD_SIZE*BLOCK_WORDS-1:0]   block_a,
  output logic [WORD_SIZE*BLOCK_WORDS-1:0]   block_b
);

  localparam int unsigned AW = field_w(MEM_WORDS);
  localparam int unsigned OW = field_w(BLOCK_WORDS);
  localparam int unsigned BW = AW - OW;

  // Words are stored XOR their own address so a cleared array reads back as word i = i.
  logic [WORD_SIZE-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (write) mem[addr] <= wdata ^ WORD_SIZE'(addr);
  end

  for (genvar k = 0; k < BLOCK_WORDS; k++) begin : g_word
    logic [AW-1:0] wa;
    logic [AW-1:0] wb;
    assign wa = {addr[AW-1:OW], OW'(k)};
    assign wb = {addr[AW-1:OW] + BW'(1), OW'(k)};
    assign block_a[k*WORD_SIZE +: WORD_SIZE] = read ? (mem[wa] ^ WORD_SIZE'(wa)) : '0;
    assign block_b[k*WORD_SIZE +: WORD_SIZE] = read ? (mem[wb] ^ WORD_SIZE'(wb)) : '0;
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through data cache with next-block prefetch on read miss.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
  parameter int unsigned BLOCK_WORDS  = DEF_BLOCK_WORDS,
  parameter int unsigned LINES        = DEF_LINES,
  parameter int unsigned MEM_WORDS    = DEF_MEM_WORDS,
  parameter int unsigned MISS_LATENCY = DEF_MISS_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic                 read_en,
  input  logic                 write_en,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 over
);

  localparam int unsigned BLOCK_SIZE = WORD_SIZE * BLOCK_WORDS;
  localparam int unsigned AW = field_w(MEM_WORDS);
  localparam int unsigned OW = field_w(BLOCK_WORDS);
  localparam int unsigned IW = field_w(LINES);
  localparam int unsigned TW = tag_w(MEM_WORDS, BLOCK_WORDS, LINES);
  localparam int unsigned BW = AW - OW;
  localparam int unsigned CW = field_w(MISS_LATENCY);

  cache_state_t state_q, state_d;
  logic [WORD_SIZE-1:0] req_addr_q, req_wdata_q, rdata_q, rdata_d;
  logic                 req_write_q, over_q, over_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sample_c, fill_c, fill_done_c, wr_done_c;

  logic [WORD_SIZE-1:0] data_arr [LINES][BLOCK_WORDS];
  logic [TW-1:0]        tag_arr  [LINES];
  logic [LINES-1:0]     valid_q;

  logic [AW-1:0]         ra;
  logic [OW-1:0]         off;
  logic [IW-1:0]         idx, idx_b;
  logic [TW-1:0]         tag, tag_b;
  logic [BW-1:0]         blk_b;
  logic                  hit_c, req_active_c;
  logic [WORD_SIZE-1:0]  line_word_c, fill_word_c;
  logic [BLOCK_SIZE-1:0] block_a, block_b;

  assign ra           = req_addr_q[AW-1:0];
  assign off          = ra[OW-1:0];
  assign idx          = ra[OW+IW-1:OW];
  assign tag          = ra[AW-1:OW+IW];
  assign blk_b        = ra[AW-1:OW] + BW'(1);
  assign idx_b        = blk_b[IW-1:0];
  assign tag_b        = blk_b[BW-1:IW];
  assign hit_c        = valid_q[idx] && (tag_arr[idx] == tag);
  assign line_word_c  = data_arr[idx][off];
  assign req_active_c = (read_en || write_en) && (addr == req_addr_q);
  assign rdata        = rdata_q;
  assign over         = over_q;

  always_comb begin
    fill_word_c = '0;
    for (int unsigned k = 0; k < BLOCK_WORDS; k++) begin
      if (off == OW'(k)) fill_word_c = block_a[k*WORD_SIZE +: WORD_SIZE];
    end
  end

  data_mem #(
    .WORD_SIZE  (WORD_SIZE),
    .BLOCK_WORDS(BLOCK_WORDS),
    .MEM_WORDS  (MEM_WORDS)
  ) u_mem (
    .clk    (clk),
    .addr   (ra),
    .read   (fill_c),
    .write  (wr_done_c),
    .wdata  (req_wdata_q),
    .block_a(block_a),
    .block_b(block_b)
  );

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    over_d      = over_q;
    sample_c    = 1'b0;
    fill_c      = 1'b0;
    fill_done_c = 1'b0;
    wr_done_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        over_d = 1'b0;
        if (read_en || write_en) begin
          sample_c = 1'b1;
          state_d  = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        cnt_d = '0;
        if (req_write_q) begin
          state_d = S_WRITE;
        end else if (hit_c) begin
          state_d = S_DONE;
          rdata_d = line_word_c;
          over_d  = 1'b1;
        end else begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        fill_c = 1'b1;
        if (cnt_q == CW'(MISS_LATENCY - 1)) begin
          fill_done_c = 1'b1;
          state_d     = S_DONE;
          rdata_d     = fill_word_c;
          over_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: begin
        if (cnt_q == CW'(MISS_LATENCY - 1)) begin
          wr_done_c = 1'b1;
          state_d   = S_DONE;
          over_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (!req_active_c) begin
          state_d = S_IDLE;
          over_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        over_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      over_q      <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_write_q <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      over_q  <= over_d;
      if (sample_c) begin
        req_addr_q  <= addr;
        req_wdata_q <= wdata;
        req_write_q <= write_en;
      end
      if (fill_done_c) begin
        valid_q[idx]   <= 1'b1;
        valid_q[idx_b] <= 1'b1;
      end
    end
  end

  // Data and tag arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_done_c) begin
      for (int unsigned k = 0; k < BLOCK_WORDS; k++) begin
        data_arr[idx][k]   <= block_a[k*WORD_SIZE +: WORD_SIZE];
        data_arr[idx_b][k] <= block_b[k*WORD_SIZE +: WORD_SIZE];
      end
      tag_arr[idx]   <= tag;
      tag_arr[idx_b] <= tag_b;
    end else if (wr_done_c && hit_c) begin
      data_arr[idx][off] <= req_wdata_q;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed, table-driven bench for data_cache: latency, data, prefetch, write-through and reset.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata, rdata;
  logic        read_en, write_en, over;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_cache dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .read_en (read_en),
    .write_en(write_en),
    .wdata   (wdata),
    .rdata   (rdata),
    .over    (over)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic re, input logic [31:0] a,
                              input logic [31:0] wd, input int lat,
                              input logic chk_rd, input logic [31:0] rd);
    vec_t v;
    v.we = we; v.re = re; v.a = a; v.wd = wd; v.lat = lat; v.chk_rd = chk_rd; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a request starting just after an edge; count edges until over (bounded).
  task automatic do_req(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd);
    write_en = we; read_en = re; addr = a; wdata = wd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!over && lat < 40);
    rd = rdata;
  endtask

  task automatic release_req(input string name);
    read_en = 1'b0; write_en = 1'b0;
    @(posedge clk); #1;
    check({name, " over drop"}, 32'(over), 32'd0);
  endtask

  task automatic run_one(input string name, input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int exp_lat, input logic chk_rd, input logic [31:0] exp_rd);
    int          lat;
    logic [31:0] rd;
    do_req(we, re, a, wd, lat, rd);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    if (chk_rd) check({name, " rdata"}, rd, exp_rd);
    release_req(name);
  endtask

  initial begin
    rst_n = 1'b0; read_en = 1'b0; write_en = 1'b0; addr = '0; wdata = '0;

    // Memory starts as word i = i; lines 0/1 hold blocks 0/1 after the first miss.
    vecs.push_back(mk(0, 1, 32'd0,    '0,            10, 1, 32'd0));
    vecs.push_back(mk(0, 1, 32'd1,    '0,            2,  1, 32'd1));
    vecs.push_back(mk(0, 1, 32'd2,    '0,            2,  1, 32'd2));
    vecs.push_back(mk(0, 1, 32'd3,    '0,            2,  1, 32'd3));
    vecs.push_back(mk(0, 1, 32'd4,    '0,            2,  1, 32'd4));
    vecs.push_back(mk(0, 1, 32'd7,    '0,            2,  1, 32'd7));
    vecs.push_back(mk(1, 0, 32'd2,    32'hDEADBEEF,  10, 0, '0));
    vecs.push_back(mk(0, 1, 32'd2,    '0,            2,  1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 32'd64,   '0,            10, 1, 32'd64));
    vecs.push_back(mk(0, 1, 32'd0,    '0,            10, 1, 32'd0));
    vecs.push_back(mk(0, 1, 32'd2,    '0,            2,  1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1, 32'd5,    32'd7,         10, 0, '0));
    vecs.push_back(mk(0, 1, 32'd5,    '0,            2,  1, 32'd7));
    vecs.push_back(mk(1, 0, 32'd100,  32'h0000_1234, 10, 0, '0));
    vecs.push_back(mk(0, 1, 32'd100,  '0,            10, 1, 32'h0000_1234));
    vecs.push_back(mk(0, 1, 32'd64,   '0,            10, 1, 32'd64));
    vecs.push_back(mk(0, 1, 32'd1023, '0,            10, 1, 32'd1023));
    vecs.push_back(mk(0, 1, 32'd0,    '0,            2,  1, 32'd0));
    vecs.push_back(mk(0, 1, 32'd2,    '0,            2,  1, 32'hDEADBEEF));

    repeat (3) @(posedge clk);
    #1;
    check("reset over", 32'(over), 32'd0);
    check("reset rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_one($sformatf("v%0d", i), vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].wd,
              vecs[i].lat, vecs[i].chk_rd, vecs[i].rd);
    end

    // Hold: over and rdata stay put while the request is held, drop on addr change.
    begin
      int          lat;
      logic [31:0] rd;
      do_req(1'b0, 1'b1, 32'd3, '0, lat, rd);
      check("hold latency", 32'(lat), 32'd2);
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        check($sformatf("hold over c%0d", c), 32'(over), 32'd1);
        check($sformatf("hold rdata c%0d", c), rdata, 32'd3);
      end
      addr = 32'd4;
      @(posedge clk); #1;
      check("addr change over", 32'(over), 32'd0);
      read_en = 1'b0;
      @(posedge clk); #1;
    end

    // Reset mid-FILL clears outputs at once and invalidates the cache.
    read_en = 1'b1; addr = 32'd8;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midfill over", 32'(over), 32'd0);
    check("midfill rdata", rdata, 32'd0);
    read_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_one("post-reset a0", 1'b0, 1'b1, 32'd0, '0, 10, 1'b1, 32'd0);
    run_one("post-reset a1", 1'b0, 1'b1, 32'd1, '0, 2,  1'b1, 32'd1);
    run_one("post-reset a2", 1'b0, 1'b1, 32'd2, '0, 2,  1'b1, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
